// File: rtl/tcas_rx_pulse_meas_pkg.sv
// Shared types and helpers for the TCAS receive pulse measurement path.
// State encoding, magnitude shift constants and packed-channel slice offsets.
package tcas_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // beta = 1/4 + 1/8 in the alpha-max-beta-min approximation
  localparam int MAG_SH_A = 2;
  localparam int MAG_SH_B = 3;

  function automatic int ch_lsb(input int k, input int w);
    return k * w;
  endfunction

  function automatic int peak_lsb(input int k, input int w);
    return k * (w + 1);
  endfunction

endpackage

// File: rtl/tcas_rx_pulse_meas_if.sv
// Sample stream in and report stream out; master drives samples and accepts reports.
// Reports use valid/ready; the sample side has no backpressure.
interface tcas_rx_pulse_meas_if #(
  parameter int N_CH  = 4,
  parameter int W     = 16,
  parameter int CNT_W = 12,
  parameter int TS_W  = 32
);
  logic                    in_valid;
  logic [N_CH*W-1:0]       in_i;
  logic [N_CH*W-1:0]       in_q;
  logic                    out_valid;
  logic                    out_ready;
  logic [N_CH*(W+1)-1:0]   out_peak;
  logic [CNT_W-1:0]        out_width;
  logic [TS_W-1:0]         out_ts;
  logic                    out_trunc;

  modport master (
    output in_valid, in_i, in_q, out_ready,
    input  out_valid, out_peak, out_width, out_ts, out_trunc
  );

  modport slave (
    input  in_valid, in_i, in_q, out_ready,
    output out_valid, out_peak, out_width, out_ts, out_trunc
  );
endinterface

// File: rtl/tcas_rx_pulse_meas_mag_approx.sv
// Saturating abs plus alpha-max-beta-min magnitude; 2-cycle latency, free-running,
// no backpressure.
module mag_approx
  import tcas_rx_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [W-1:0] i,
  input  logic signed [W-1:0] q,
  output logic [W:0]          mag
);

  logic [W-2:0] ai, aq;
  logic [W-2:0] mx_q, mn_q;

  // The most negative code has no positive twin, so it clamps to full scale.
  function automatic logic [W-2:0] abs_sat(input logic signed [W-1:0] x);
    logic signed [W-1:0] n;
    n = -x;
    if (!x[W-1])
      return x[W-2:0];
    else if (x[W-2:0] == '0)
      return '1;
    else
      return n[W-2:0];
  endfunction

  assign ai = abs_sat(i);
  assign aq = abs_sat(q);

  always_ff @(posedge clk) begin
    if (reset) begin
      mx_q <= '0;
      mn_q <= '0;
      mag  <= '0;
    end else begin
      mx_q <= (ai >= aq) ? ai : aq;
      mn_q <= (ai >= aq) ? aq : ai;
      mag  <= (W+1)'(mx_q) + (W+1)'(mn_q >> MAG_SH_A) + (W+1)'(mn_q >> MAG_SH_B);
    end
  end

endmodule

// File: rtl/tcas_rx_pulse_meas.sv
// Per-pulse amplitude/width/timestamp measurement over N_CH channels; report 2 cycles
// after pulse end plus one DONE cycle, one-deep output buffer, new reports dropped when full.
module tcas_rx_pulse_meas
  import tcas_rx_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int W       = 16,
  parameter int CNT_W   = 12,
  parameter int TS_W    = 32,
  parameter int MAX_LEN = 2047
) (
  input  logic                 clk,
  input  logic                 reset,
  tcas_rx_pulse_meas_if.slave  bus,
  input  logic [W:0]           thr,
  input  logic [3:0]           min_len,
  input  logic                 ovf_clr,
  output logic                 ovf,
  output logic                 busy
);

  typedef struct packed {
    logic [N_CH*(W+1)-1:0] peak;
    logic [CNT_W-1:0]      width;
    logic [TS_W-1:0]       ts;
    logic                  trunc;
  } rpt_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

  logic [W:0]      mag [N_CH];
  logic [W:0]      mmax;
  logic [1:0]      vld_pipe;
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ts_pipe [2];
  logic            s_valid;
  logic [TS_W-1:0] ts_s;
  logic            above;
  logic [3:0]      ml;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [W:0]       peak [N_CH];
  logic [W:0]       peak_n [N_CH];
  logic [TS_W-1:0]  ts_cap, ts_cap_n;
  logic             trunc, trunc_n;
  logic             wait_low, wait_low_n;

  rpt_t rpt_d, rpt_q;
  logic out_valid_q;
  logic slot_free;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    mag_approx #(.W(W)) u_mag (
      .clk   (clk),
      .reset (reset),
      .i     (bus.in_i[ch_lsb(k, W) +: W]),
      .q     (bus.in_q[ch_lsb(k, W) +: W]),
      .mag   (mag[k])
    );
  end

  always_comb begin
    mmax = '0;
    for (int k = 0; k < N_CH; k++)
      if (mag[k] > mmax) mmax = mag[k];
  end

  // Strobe and timestamp ride alongside the magnitude pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe   <= '0;
      ts_cnt     <= '0;
      ts_pipe[0] <= '0;
      ts_pipe[1] <= '0;
    end else begin
      vld_pipe   <= {vld_pipe[0], bus.in_valid};
      ts_pipe[0] <= ts_cnt;
      ts_pipe[1] <= ts_pipe[0];
      if (bus.in_valid) ts_cnt <= ts_cnt + 1'b1;
    end
  end

  assign s_valid = vld_pipe[1];
  assign ts_s    = ts_pipe[1];
  assign above   = (mmax >= thr);
  assign ml      = (min_len == 4'd0) ? 4'd1 : min_len;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      ts_cap   <= '0;
      trunc    <= 1'b0;
      wait_low <= 1'b0;
      for (int k = 0; k < N_CH; k++) peak[k] <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      ts_cap   <= ts_cap_n;
      trunc    <= trunc_n;
      wait_low <= wait_low_n;
      for (int k = 0; k < N_CH; k++) peak[k] <= peak_n[k];
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    ts_cap_n   = ts_cap;
    trunc_n    = trunc;
    wait_low_n = wait_low;
    for (int k = 0; k < N_CH; k++) peak_n[k] = peak[k];

    // After a timeout the input must drop below threshold before re-arming.
    if (s_valid && !above) wait_low_n = 1'b0;

    unique case (state)
      IDLE: begin
        if (s_valid && above && !wait_low) begin
          cnt_n    = CNT_W'(1);
          ts_cap_n = ts_s;
          trunc_n  = 1'b0;
          for (int k = 0; k < N_CH; k++) peak_n[k] = mag[k];
          state_n  = (ml <= 4'd1) ? ACTIVE : ARM;
        end
      end
      ARM: begin
        if (s_valid) begin
          if (!above) begin
            state_n = IDLE;
          end else begin
            cnt_n = cnt + 1'b1;
            for (int k = 0; k < N_CH; k++)
              if (mag[k] > peak[k]) peak_n[k] = mag[k];
            if (cnt_n == CNT_W'(ml)) state_n = ACTIVE;
          end
        end
      end
      ACTIVE: begin
        if (s_valid) begin
          if (!above) begin
            state_n = DONE;
            trunc_n = 1'b0;
          end else begin
            cnt_n = cnt + 1'b1;
            for (int k = 0; k < N_CH; k++)
              if (mag[k] > peak[k]) peak_n[k] = mag[k];
            if (cnt_n == MAX_CNT) begin
              state_n    = DONE;
              trunc_n    = 1'b1;
              wait_low_n = 1'b1;
            end
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    rpt_d       = '0;
    rpt_d.width = cnt;
    rpt_d.ts    = ts_cap;
    rpt_d.trunc = trunc;
    for (int k = 0; k < N_CH; k++)
      rpt_d.peak[peak_lsb(k, W) +: (W+1)] = peak[k];
  end

  assign slot_free = !out_valid_q || bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      rpt_q       <= '0;
      ovf         <= 1'b0;
    end else begin
      if (state == DONE && slot_free) begin
        rpt_q       <= rpt_d;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (state == DONE && !slot_free) ovf <= 1'b1;
      else if (ovf_clr)                ovf <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_peak  = rpt_q.peak;
  assign bus.out_width = rpt_q.width;
  assign bus.out_ts    = rpt_q.ts;
  assign bus.out_trunc = rpt_q.trunc;
  assign busy          = (state != IDLE);

endmodule
